// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: per-stage stall requests and redirect sources in,
// merged stall vector, flush/redirect target and perf counters out.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stallreq_if;
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_mem;
  logic             except_valid;
  logic             except_is_eret;
  logic             except_is_refill;
  logic [31:0]      cp0_epc;
  logic             refetch_valid;
  logic [31:0]      refetch_pc;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             busy;
  logic [CNT_W-1:0] perf_stall_cycles;
  logic [CNT_W-1:0] perf_flush_count;

  // Pipeline side: raises requests, obeys stall/flush.
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output except_valid, except_is_eret, except_is_refill, cp0_epc,
    output refetch_valid, refetch_pc,
    input  stall, flush, new_pc, busy,
    input  perf_stall_cycles, perf_flush_count
  );

  // Scheduler side.
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  except_valid, except_is_eret, except_is_refill, cp0_epc,
    input  refetch_valid, refetch_pc,
    output stall, flush, new_pc, busy,
    output perf_stall_cycles, perf_flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline; defers redirects until the
// memory bus is idle. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
  parameter logic [31:0] REFILL_VECTOR = 32'hBFC00200,
  parameter int          CNT_W         = 32
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic        flush_q;

  logic        redirect_req;
  logic [31:0] target_sel;
  logic [5:0]  stall_enc;

  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  assign redirect_req = bus.except_valid | bus.refetch_valid;

  // Exceptions outrank refetch; eret outranks refill inside an exception.
  always_comb begin
    target_sel = bus.refetch_pc;
    if (bus.except_valid) begin
      if (bus.except_is_eret) begin
        target_sel = bus.cp0_epc;
      end else if (bus.except_is_refill) begin
        target_sel = REFILL_VECTOR;
      end else begin
        target_sel = EXC_VECTOR;
      end
    end
  end

  always_comb begin
    stall_enc = 6'b000000;
    if (bus.stallreq_mem) begin
      stall_enc = 6'b011111;
    end else if (bus.stallreq_ex) begin
      stall_enc = 6'b001111;
    end else if (bus.stallreq_id) begin
      stall_enc = 6'b000111;
    end else if (bus.stallreq_if) begin
      stall_enc = 6'b000011;
    end
  end

  // A request seen right after a flush comes from a stage that is being
  // killed, so it is dropped; this also keeps flush from repeating back to back.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    stall_o  = 6'b000000;
    flush_o  = 1'b0;
    new_pc_o = 32'h0;
    busy_o   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (redirect_req && !flush_q) begin
            if (bus.stallreq_mem) begin
              target_d = target_sel;
              state_d  = PEND;
              stall_o  = 6'b111111;
            end else begin
              flush_o  = 1'b1;
              new_pc_o = target_sel;
            end
          end else begin
            stall_o = stall_enc;
          end
        end
        PEND: begin
          stall_o = 6'b111111;
          busy_o  = 1'b1;
          if (!bus.stallreq_mem) begin
            state_d = FLUSH;
          end
        end
        FLUSH: begin
          flush_o  = 1'b1;
          new_pc_o = target_q;
          busy_o   = 1'b1;
          state_d  = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= 32'h0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      flush_q  <= flush_o;
    end
  end

  assign bus.stall  = stall_o;
  assign bus.flush  = flush_o;
  assign bus.new_pc = new_pc_o;
  assign bus.busy   = busy_o;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_o[0] && !flush_o) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_o) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.perf_stall_cycles = stall_cnt_q;
  assign bus.perf_flush_count  = flush_cnt_q;
`else
  assign bus.perf_stall_cycles = '0;
  assign bus.perf_flush_count  = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage MIPS pipeline (pc, ic, id, ex, mem, wb).
- Merges per-stage stall requests into the 6-bit stall bus.
- Sequences exception, eret and TLB-refetch redirects. A redirect arriving while a memory/cache transaction is stalled is held until the bus goes idle, so no transaction is aborted mid-flight.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry PC.
- REFILL_VECTOR, 32'hBFC00200, TLB refill entry PC.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- stallreq_if  in  1  fetch/icache not ready.
- stallreq_id  in  1  decode hazard (load-use, multicycle decode).
- stallreq_ex  in  1  ex busy (div/mul).
- stallreq_mem  in  1  dcache/bus transaction in progress.
- except_valid  in  1  mem stage reports exception (excepttype != 0).
- except_is_eret  in  1  qualifies except_valid as eret.
- except_is_refill  in  1  qualifies except_valid as TLB refill.
- cp0_epc  in  32  EPC for eret.
- refetch_valid  in  1  TLB-write refetch request (again flag) from mem.
- refetch_pc  in  32  PC to refetch.
- stall  out  6  stall[0]=pc … stall[5]=wb; 1 = stop.
- flush  out  1  kill all stages, one cycle.
- new_pc  out  32  redirect target, valid when flush=1.
- busy  out  1  redirect pending (state != IDLE).
- perf_stall_cycles  out  CNT_W  optional, see below.
- perf_flush_count  out  CNT_W  optional, see below.

Behaviour:
- Reset values: stall=0, flush=0, new_pc=0, busy=0; state=IDLE; latched target=0.
- Redirect request R = except_valid | refetch_valid.
- Redirect priority: except_valid over refetch_valid.
- Target selection:
  - eret → cp0_epc.
  - refill → REFILL_VECTOR.
  - other exception → EXC_VECTOR.
  - refetch → refetch_pc.
- Stall encoding in IDLE, with no redirect. Highest asserted request wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- States: IDLE, PEND, FLUSH.
- IDLE, R=1 and stallreq_mem=0: combinational flush=1, new_pc=target, stall=0. Stay IDLE (zero-latency redirect).
- IDLE, R=1 and stallreq_mem=1: latch target; go to PEND.
  - In that same cycle: flush=0, stall=6'b111111.
- PEND:
  - stall=6'b111111, busy=1; R inputs ignored.
  - When stallreq_mem falls, go to FLUSH on the next edge.
- FLUSH:
  - flush=1, new_pc=latched target, stall=0, busy=1.
  - Unconditionally return to IDLE.
- flush has priority over every stall request. A stall request coinciding with flush is ignored for that cycle.
- A new R while busy=1 is dropped. The upstream stages are flushed, so they cannot re-raise it.
- rst in any state: forces IDLE next edge; outputs at reset values.
- flush is never asserted on two consecutive cycles.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_cycles increments each cycle stall[0]=1 and flush=0.
  - perf_flush_count increments each cycle flush=1.
  - Both wrap modulo 2^CNT_W; both cleared by rst.
- Undefined: both ports tied to 0; no counter flops.

Test Plan:
- stallreq_ex=1, stallreq_id=1 → stall=6'b001111. Then only stallreq_if=1 → 6'b000011. None → 0.
- except_valid=1 (not eret/refill), stallreq_mem=0 → same cycle flush=1, new_pc=32'hBFC00380, stall=0. Next cycle flush=0.
- except_is_eret, cp0_epc=32'h80001234, stallreq_mem=1 for 3 more cycles:
  - stall=6'b111111 and busy=1 for 4 cycles.
  - Then flush=1, new_pc=32'h80001234 exactly one cycle after stallreq_mem falls.
- except_valid with except_is_refill and refetch_valid (refetch_pc=32'h80000010) in the same cycle → new_pc=32'hBFC00200.
- In PEND, assert rst → next cycle state IDLE, stall=0, flush=0, busy=0, no later flush.
- With PIPE_CTRL_PERF_EN:
  - 5 cycles of stallreq_id, then one exception → perf_stall_cycles=5, perf_flush_count=1.
  - rst clears both to 0.
